// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity encoding, TX state encoding and frame-length helper
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic int frame_cycles(input int data_width, input int clks_per_bit,
                                        input int parity, input int stop_bits);
        return clks_per_bit * (1 + data_width + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter emitting a one-cycle tick on the last cycle of each bit
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic uart_clk,
    input  logic rst,
    input  logic restart,
    input  logic run,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || !run || (cnt == CNT_LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = run && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmitter with a one-word holding register for back-to-back frames
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  uart_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done
);

    generate
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
            $error("uart_tx_framer: DATA_WIDTH must be 5..9");
        end
        if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
            $error("uart_tx_framer: CLKS_PER_BIT must be >= 1");
        end
        if (PARITY != PARITY_NONE && PARITY != PARITY_ODD && PARITY != PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx_framer: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_framer: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD_PAR   = (PARITY == PARITY_ODD);

    tx_state_t              state, state_next;
    logic [DATA_WIDTH-1:0]  shifter, shifter_next;
    logic [DATA_WIDTH-1:0]  hold_data, hold_data_next;
    logic                   hold_full, hold_full_next;
    logic                   par_bit, par_next;
    logic [IDX_W-1:0]       bit_idx, bit_idx_next;
    logic                   stop_cnt, stop_cnt_next;
    logic                   tx_out_next, tx_busy_next, tx_done_next;

    logic                   bit_tick;
    logic                   accept, frame_end, load, load_from_hold, load_direct;
    logic [DATA_WIDTH-1:0]  load_word;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .uart_clk (uart_clk),
        .rst      (rst),
        .restart  (load),
        .run      (state != TX_IDLE),
        .bit_tick (bit_tick)
    );

    assign tx_ready = !hold_full;

    always_comb begin
        accept         = tx_valid && !hold_full;
        frame_end      = (state == TX_STOP) && bit_tick && (stop_cnt == STOP_LAST);
        load_from_hold = frame_end && hold_full;
        load_direct    = accept && ((state == TX_IDLE) || frame_end);
        load           = load_from_hold || load_direct;
        // A direct load implies the holding register is empty, so hold_full selects the source.
        load_word      = hold_full ? hold_data : tx_data;

        state_next     = state;
        shifter_next   = shifter;
        hold_data_next = hold_data;
        hold_full_next = hold_full;
        par_next       = par_bit;
        bit_idx_next   = bit_idx;
        stop_cnt_next  = stop_cnt;

        if (load_from_hold) begin
            hold_full_next = 1'b0;
        end else if (accept && !load_direct) begin
            hold_data_next = tx_data;
            hold_full_next = 1'b1;
        end

        if (load) begin
            shifter_next  = load_word;
            par_next      = (^load_word) ^ ODD_PAR;
            bit_idx_next  = '0;
            stop_cnt_next = 1'b0;
        end else if (bit_tick && state == TX_DATA) begin
            shifter_next = shifter >> 1;
            bit_idx_next = bit_idx + IDX_W'(1);
        end else if (bit_tick && state == TX_STOP) begin
            stop_cnt_next = !stop_cnt;
        end

        case (state)
            TX_IDLE:   if (load) state_next = TX_START;
            TX_START:  if (bit_tick) state_next = TX_DATA;
            TX_DATA:   if (bit_tick && bit_idx == LAST_BIT)
                           state_next = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
            TX_PARITY: if (bit_tick) state_next = TX_STOP;
            TX_STOP:   if (frame_end) state_next = load ? TX_START : TX_IDLE;
            default:   state_next = TX_IDLE;
        endcase

        case (state_next)
            TX_START:  tx_out_next = 1'b0;
            TX_DATA:   tx_out_next = shifter_next[0];
            TX_PARITY: tx_out_next = par_next;
            default:   tx_out_next = 1'b1;
        endcase
        tx_busy_next = (state_next != TX_IDLE);
        tx_done_next = frame_end;
    end

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state     <= TX_IDLE;
            shifter   <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            par_bit   <= 1'b0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            tx_out    <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            shifter   <= shifter_next;
            hold_data <= hold_data_next;
            hold_full <= hold_full_next;
            par_bit   <= par_next;
            bit_idx   <= bit_idx_next;
            stop_cnt  <= stop_cnt_next;
            tx_out    <= tx_out_next;
            tx_busy   <= tx_busy_next;
            tx_done   <= tx_done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - directed self-checking bench for uart_tx_framer
module tb_uart_tx_framer;

    logic       uart_clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data  [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic       tx_out   [4];
    logic       tx_busy  [4];
    logic       tx_done  [4];

    int total = 0;
    int bad   = 0;

    always #5 uart_clk = ~uart_clk;

    uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) u_def (
        .uart_clk(uart_clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .tx_out(tx_out[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(1)) u_even (
        .uart_clk(uart_clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .tx_out(tx_out[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY(1), .STOP_BITS(1)) u_odd (
        .uart_clk(uart_clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .tx_out(tx_out[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_slow (
        .uart_clk(uart_clk), .rst(rst), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
        .tx_ready(tx_ready[3]), .tx_out(tx_out[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));

    task automatic offer(input int k, input logic [7:0] w);
        @(negedge uart_clk);
        tx_data[k]  = w;
        tx_valid[k] = 1'b1;
        @(posedge uart_clk);
        #1 tx_valid[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end
        #3;
        for (int k = 0; k < 4; k++) begin
            total++; if (tx_out[k] !== 1'b1) begin bad++; $display("FAIL reset_tx_out[%0d] got=%b exp=1", k, tx_out[k]); end
            total++; if (tx_ready[k] !== 1'b1) begin bad++; $display("FAIL reset_tx_ready[%0d] got=%b exp=1", k, tx_ready[k]); end
            total++; if (tx_busy[k] !== 1'b0) begin bad++; $display("FAIL reset_tx_busy[%0d] got=%b exp=0", k, tx_busy[k]); end
            total++; if (tx_done[k] !== 1'b0) begin bad++; $display("FAIL reset_tx_done[%0d] got=%b exp=0", k, tx_done[k]); end
        end
        repeat (2) @(negedge uart_clk);
        rst = 1'b0;
    endtask

    task automatic test_default_a5;
        int e[10] = '{0,1,0,1,0,0,1,0,1,1};
        offer(0, 8'hA5);
        for (int i = 1; i <= 12; i++) begin
            @(negedge uart_clk);
            if (i <= 10) begin
                total++; if (tx_out[0] !== 1'(e[i-1])) begin bad++; $display("FAIL a5_bit cyc=%0d got=%b exp=%0d", i, tx_out[0], e[i-1]); end
                total++; if (tx_busy[0] !== 1'b1) begin bad++; $display("FAIL a5_busy cyc=%0d got=%b exp=1", i, tx_busy[0]); end
            end else begin
                total++; if (tx_out[0] !== 1'b1) begin bad++; $display("FAIL a5_idle_out cyc=%0d got=%b exp=1", i, tx_out[0]); end
                total++; if (tx_busy[0] !== 1'b0) begin bad++; $display("FAIL a5_idle_busy cyc=%0d got=%b exp=0", i, tx_busy[0]); end
            end
            total++; if (tx_done[0] !== (i == 11)) begin bad++; $display("FAIL a5_done cyc=%0d got=%b exp=%b", i, tx_done[0], (i == 11)); end
        end
    endtask

    task automatic test_parity;
        int         kk[3]     = '{1, 2, 1};
        logic [7:0] ww[3]     = '{8'hA5, 8'hA5, 8'h07};
        int         e[3][11]  = '{'{0,1,0,1,0,0,1,0,1,0,1},
                                  '{0,1,0,1,0,0,1,0,1,1,1},
                                  '{0,1,1,1,0,0,0,0,0,1,1}};
        for (int c = 0; c < 3; c++) begin
            offer(kk[c], ww[c]);
            for (int i = 1; i <= 12; i++) begin
                @(negedge uart_clk);
                if (i <= 11) begin
                    total++; if (tx_out[kk[c]] !== 1'(e[c][i-1])) begin bad++; $display("FAIL parity_case%0d cyc=%0d got=%b exp=%0d", c, i, tx_out[kk[c]], e[c][i-1]); end
                end
                total++; if (tx_done[kk[c]] !== (i == 12)) begin bad++; $display("FAIL parity_done case%0d cyc=%0d got=%b exp=%b", c, i, tx_done[kk[c]], (i == 12)); end
            end
        end
    endtask

    task automatic test_back_to_back;
        int e[20] = '{0,1,0,1,0,1,0,1,0,1, 0,1,1,1,1,0,0,0,0,1};
        logic exp_ready;
        @(negedge uart_clk);
        tx_data[0]  = 8'h55;
        tx_valid[0] = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge uart_clk);
            exp_ready = !(i >= 2 && i <= 10);
            if (i <= 20) begin
                total++; if (tx_out[0] !== 1'(e[i-1])) begin bad++; $display("FAIL b2b_bit cyc=%0d got=%b exp=%0d", i, tx_out[0], e[i-1]); end
                total++; if (tx_busy[0] !== 1'b1) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b exp=1", i, tx_busy[0]); end
            end
            total++; if (tx_ready[0] !== exp_ready) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, tx_ready[0], exp_ready); end
            total++; if (tx_done[0] !== (i == 11 || i == 21)) begin bad++; $display("FAIL b2b_done cyc=%0d got=%b exp=%b", i, tx_done[0], (i == 11 || i == 21)); end
            if (i == 1) tx_data[0] = 8'h0F;
            if (i == 2) tx_valid[0] = 1'b0;
        end
    endtask

    task automatic test_valid_toggle;
        int e[20] = '{0,1,1,0,0,0,0,1,1,1, 0,1,0,0,0,0,0,0,1,1};
        offer(0, 8'hC3);
        for (int i = 1; i <= 23; i++) begin
            @(negedge uart_clk);
            if (i <= 20) begin
                total++; if (tx_out[0] !== 1'(e[i-1])) begin bad++; $display("FAIL toggle_bit cyc=%0d got=%b exp=%0d", i, tx_out[0], e[i-1]); end
            end else begin
                total++; if (tx_out[0] !== 1'b1) begin bad++; $display("FAIL toggle_idle_out cyc=%0d got=%b exp=1", i, tx_out[0]); end
            end
            if (i >= 22) begin
                total++; if (tx_busy[0] !== 1'b0) begin bad++; $display("FAIL toggle_idle_busy cyc=%0d got=%b exp=0", i, tx_busy[0]); end
            end
            if (i == 1) begin
                tx_data[0]  = 8'h81;
                tx_valid[0] = 1'b1;
            end else if (i == 2) begin
                tx_data[0]  = 8'hFF;
                tx_valid[0] = 1'b0;
            end else if (i <= 9) begin
                tx_valid[0] = (i % 2 == 1);
            end else begin
                tx_valid[0] = 1'b0;
            end
        end
    endtask

    task automatic test_slow_two_stop;
        int lows = 0;
        offer(3, 8'h00);
        for (int i = 1; i <= 46; i++) begin
            @(negedge uart_clk);
            if (i <= 44) begin
                if (tx_out[3] === 1'b0) lows++;
                total++; if (tx_out[3] !== (i > 36)) begin bad++; $display("FAIL slow_bit cyc=%0d got=%b exp=%b", i, tx_out[3], (i > 36)); end
            end
            total++; if (tx_done[3] !== (i == 45)) begin bad++; $display("FAIL slow_done cyc=%0d got=%b exp=%b", i, tx_done[3], (i == 45)); end
        end
        total++; if (lows !== 36) begin bad++; $display("FAIL slow_low_count got=%0d exp=36", lows); end
    endtask

    task automatic test_reset_mid_frame;
        int e[10] = '{0,0,0,1,1,1,1,0,0,1};
        offer(0, 8'hFF);
        for (int i = 1; i <= 5; i++) begin
            @(negedge uart_clk);
            if (i == 1) begin
                tx_data[0]  = 8'h99;
                tx_valid[0] = 1'b1;
            end else if (i == 2) begin
                tx_valid[0] = 1'b0;
                total++; if (tx_ready[0] !== 1'b0) begin bad++; $display("FAIL rst_held_ready got=%b exp=0", tx_ready[0]); end
            end
        end
        total++; if (tx_busy[0] !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b exp=1", tx_busy[0]); end
        #2 rst = 1'b1;
        #1;
        total++; if (tx_out[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_out got=%b exp=1", tx_out[0]); end
        total++; if (tx_ready[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", tx_ready[0]); end
        total++; if (tx_busy[0] !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", tx_busy[0]); end
        @(negedge uart_clk);
        rst = 1'b0;
        offer(0, 8'h3C);
        for (int i = 1; i <= 24; i++) begin
            @(negedge uart_clk);
            if (i <= 10) begin
                total++; if (tx_out[0] !== 1'(e[i-1])) begin bad++; $display("FAIL rst_3c_bit cyc=%0d got=%b exp=%0d", i, tx_out[0], e[i-1]); end
            end else begin
                total++; if (tx_out[0] !== 1'b1) begin bad++; $display("FAIL rst_after_out cyc=%0d got=%b exp=1", i, tx_out[0]); end
                total++; if (tx_busy[0] !== 1'b0) begin bad++; $display("FAIL rst_after_busy cyc=%0d got=%b exp=0", i, tx_busy[0]); end
            end
            total++; if (tx_done[0] !== (i == 11)) begin bad++; $display("FAIL rst_3c_done cyc=%0d got=%b exp=%b", i, tx_done[0], (i == 11)); end
        end
    endtask

    initial begin
        test_reset;
        test_default_a5;
        test_parity;
        test_back_to_back;
        test_valid_toggle;
        test_slow_two_stop;
        test_reset_mid_frame;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
